backlight_pwm_ctrl: RTL
=======================

BACKLIGHT_PWM_CTRL -- requirements
Module: backlight_pwm_ctrl

Interface
- REQ-001: Parameter CLK_HZ, default 32768: clk frequency in Hz.
- REQ-002: Parameter TIMEOUT_S, default 3: seconds at full level before fade starts; legal range is 1..255.
- REQ-003: Parameter PWM_BITS, default 4: width of the brightness level and of the PWM counter.
- REQ-004: Parameter FADE_CYC, default 2048: clk cycles per one-step level decrement during fade; legal value is 1 or more.
- REQ-005: clk, input, 1: single clock; all logic on posedge clk.
- REQ-006: reset, input, 1: synchronous, active-high reset.
- REQ-007: btn_backlight, input, 1: backlight button, already synchronous to clk; only its rising edge is used.
- REQ-008: always_on, input, 1: mode; while 1, the backlight stays lit with no timeout.
- REQ-009: bright_set, input, PWM_BITS: target brightness level.
- REQ-010: light, output, 1: PWM drive to the backlight.
- REQ-011: level, output, PWM_BITS: current brightness level.
- REQ-012: active, output, 1: 1 whenever state is not OFF.

Function
- REQ-013: The block SHALL hold three states, OFF, ON and FADE; active is 1 in ON and FADE.
- REQ-014: Edge detect: btn_q is btn_backlight registered once; a press is btn_backlight=1 and btn_q=0 at a posedge.
- REQ-015: Press in any state: state becomes ON at that edge, level loads max(bright_set,1), and the timeout counter clears to 0.
- REQ-016: In ON with always_on=0, the timeout counter increments each cycle.
- REQ-017: At count == TIMEOUT_S*CLK_HZ-1, state becomes FADE and the fade counter clears, so ON lasts exactly TIMEOUT_S*CLK_HZ cycles.
- REQ-018: The timeout counter width is clog2(TIMEOUT_S*CLK_HZ); it never wraps.
- REQ-019: In ON, level tracks max(bright_set,1) every cycle; in FADE, bright_set is ignored.
- REQ-020: In FADE, the fade counter counts 0..FADE_CYC-1; on wrap, level decrements by 1.
- REQ-021: When level==1 and the fade counter wraps, level becomes 0 and state becomes OFF at the same edge; there is no underflow.
- REQ-022: always_on=1 forces state ON from any state, level=max(bright_set,1), and holds the timeout counter at 0.
- REQ-023: On always_on 1->0, timing restarts from count 0.
- REQ-024: A press in the same cycle as the final fade step or the timeout SHALL win: state=ON, level reloaded, counter 0.
- REQ-025: In OFF, level SHALL be 0.
- REQ-026: PWM counter: free-running, PWM_BITS wide, wraps at 2^PWM_BITS-1 -> 0.
- REQ-027: light = 1 iff pwm_cnt < level, registered, so light lags level by 1 cycle.
- REQ-028: level=0 SHALL give light constantly 0; all-ones SHALL give duty (2^PWM_BITS-1)/2^PWM_BITS.

Reset
- REQ-029: reset=1 at a posedge SHALL set state=OFF, level=0, light=0, active=0, btn_q=0, and all counters to 0.
- REQ-030: Reset SHALL override any simultaneous press or always_on, including mid-ON or mid-FADE.
- REQ-031: After reset release, a button held high SHALL NOT count as a press until it falls and rises again.

Structure
- REQ-032: A shared package SHALL hold the state enumeration (OFF=0, ON=1, FADE=2, 2 bits) and the default parameter constants.
- REQ-033: The PWM counter and comparator SHALL be one sub-module, backlight_pwm (clk, reset, level -> light).
- REQ-034: The FSM, edge detect and timers SHALL remain in the top module.

Verification (CLK_HZ=8, TIMEOUT_S=3, PWM_BITS=3, FADE_CYC=4)
- REQ-035: Reset, then press with bright_set=5 -> active=1 and level=5 next cycle; FADE after 24 cycles; level 4,3,2,1,0 at 4-cycle steps; OFF 20 cycles after FADE entry.
- REQ-036: Press again at ON cycle 20 -> counter restarts; FADE entered 24 cycles after the second press.
- REQ-037: Press during FADE at level 2 -> ON, level=bright_set; full 24-cycle timeout follows.
- REQ-038: always_on=1 for 100 cycles -> never FADE; drop it -> FADE exactly 24 cycles later; bright_set=0 -> level=1.
- REQ-039: PWM at level=3 -> light high 3 of every 8 cycles; level=0 -> light never 1.
- REQ-040: reset pulse mid-FADE with btn held high -> OFF, level=0, no re-trigger until the button is released and pressed.

Source files
------------

// File: rtl/backlight_pwm_ctrl_pkg.sv
// Shared state encoding, default parameters and sizing helper
// for the backlight PWM controller.
package backlight_pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_FADE = 2'd2
  } state_e;

  localparam int DEF_CLK_HZ    = 32768;
  localparam int DEF_TIMEOUT_S = 3;
  localparam int DEF_PWM_BITS  = 4;
  localparam int DEF_FADE_CYC  = 2048;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int ctrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/backlight_pwm.sv
// Free-running PWM counter and comparator; light is registered,
// so it trails a change of level by one clock.
module backlight_pwm
  import backlight_pwm_ctrl_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] level,
  output logic                light
);

  logic [PWM_BITS-1:0] pwmCnt_q;
  logic [PWM_BITS-1:0] pwmCnt_d;
  logic                light_q;
  logic                light_d;

  assign pwmCnt_d = pwmCnt_q + PWM_BITS'(1);
  assign light_d  = (pwmCnt_q < level);

  // Counter wraps naturally at all-ones, so full level still leaves one dark slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwmCnt_q <= '0;
      light_q  <= 1'b0;
    end else begin
      pwmCnt_q <= pwmCnt_d;
      light_q  <= light_d;
    end
  end

  assign light = light_q;

endmodule

// File: rtl/backlight_pwm_ctrl.sv
// Backlight controller: button press lights the display, a timeout
// starts a stepwise fade to off, always_on keeps it lit indefinitely.
module backlight_pwm_ctrl
  import backlight_pwm_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int TIMEOUT_S = DEF_TIMEOUT_S,
  parameter int PWM_BITS  = DEF_PWM_BITS,
  parameter int FADE_CYC  = DEF_FADE_CYC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_backlight,
  input  logic                always_on,
  input  logic [PWM_BITS-1:0] bright_set,
  output logic                light,
  output logic [PWM_BITS-1:0] level,
  output logic                active
);

  localparam int TIMEOUT_CYC = TIMEOUT_S * CLK_HZ;
  localparam int TO_W        = ctrWidth(TIMEOUT_CYC);
  localparam int FADE_W      = ctrWidth(FADE_CYC);

  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_CYC - 1);

  state_e              state_q;
  logic                btn_q;
  logic                armed_q;
  logic [TO_W-1:0]     timeoutCnt_q;
  logic [FADE_W-1:0]   fadeCnt_q;
  logic [PWM_BITS-1:0] level_q;
  logic [PWM_BITS-1:0] loadLevel_d;
  logic                press;

  // armed_q blocks a button that was already held through reset from
  // looking like a fresh press until it has been seen low once.
  assign press       = btn_backlight & ~btn_q & armed_q;
  assign loadLevel_d = (bright_set == '0) ? PWM_BITS'(1) : bright_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q   <= 1'b0;
      armed_q <= ~btn_backlight;
    end else begin
      btn_q   <= btn_backlight;
      armed_q <= armed_q | ~btn_backlight;
    end
  end

  // Mode FSM with its timers; press and always_on outrank timeout and fade steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_OFF;
      level_q      <= '0;
      timeoutCnt_q <= '0;
      fadeCnt_q    <= '0;
    end else if (always_on || press) begin
      state_q      <= ST_ON;
      level_q      <= loadLevel_d;
      timeoutCnt_q <= '0;
      fadeCnt_q    <= '0;
    end else begin
      case (state_q)
        ST_ON: begin
          level_q <= loadLevel_d;
          if (timeoutCnt_q == TO_LAST) begin
            state_q      <= ST_FADE;
            timeoutCnt_q <= '0;
            fadeCnt_q    <= '0;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + TO_W'(1);
          end
        end
        ST_FADE: begin
          if (fadeCnt_q == FADE_LAST) begin
            fadeCnt_q <= '0;
            if (level_q <= PWM_BITS'(1)) begin
              level_q <= '0;
              state_q <= ST_OFF;
            end else begin
              level_q <= level_q - PWM_BITS'(1);
            end
          end else begin
            fadeCnt_q <= fadeCnt_q + FADE_W'(1);
          end
        end
        default: begin
          state_q      <= ST_OFF;
          level_q      <= '0;
          timeoutCnt_q <= '0;
          fadeCnt_q    <= '0;
        end
      endcase
    end
  end

  assign level  = level_q;
  assign active = (state_q != ST_OFF);

  backlight_pwm #(
    .PWM_BITS(PWM_BITS)
  ) uPwm (
    .clk  (clk),
    .reset(reset),
    .level(level_q),
    .light(light)
  );

endmodule
